// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared definitions for the seven-segment scan driver:
//   - segment byte constants (bit0=a .. bit6=g, bit7=dp)
//   - conversion FSM state type
//   - pow10(): 10^N, evaluated at elaboration for the overflow limit
package seven_seg_pkg;

   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_DASH  = 8'h40;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// seven_seg_scan_driver_if
//   Load/display bus of the seven-segment scan driver.
//   value_i    : WIDTH   unsigned value to convert
//   load_i     : 1       request conversion of value_i
//   busy_o     : 1       conversion in progress, load_i ignored
//   overflow_o : 1       last loaded value >= 10^DIGITS
//   segments_o : 8       active-high segments of the enabled digit
//   digit_en_o : DIGITS  one-hot digit enable, bit0 = least significant
//   Modports: master drives value/load, slave is the driver itself.
interface seven_seg_scan_driver_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
);
   logic [WIDTH-1:0]  value_i;
   logic              load_i;
   logic              busy_o;
   logic              overflow_o;
   logic [7:0]        segments_o;
   logic [DIGITS-1:0] digit_en_o;

   modport master (
      output value_i, load_i,
      input  busy_o, overflow_o, segments_o, digit_en_o
   );

   modport slave (
      input  value_i, load_i,
      output busy_o, overflow_o, segments_o, digit_en_o
   );
endinterface

// File: rtl/seven_seg_encoder.sv
// seven_seg_encoder
//   Combinational BCD nibble to segment byte.
//   nibble_i : 4  BCD digit; codes 10..15 render as a dash
//   blank_i  : 1  force all segments off
//   seg_o    : 8  segment byte (dp always 0)
module seven_seg_encoder
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = SEG_DASH;
      if (blank_i) begin
         seg_o = SEG_BLANK;
      end else begin
         case (nibble_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Sequential double-dabble binary-to-BCD converter feeding a
//   time-multiplexed seven-segment display.
//   clk_i : system clock, rising edge
//   rst_i : asynchronous active-high reset
//   bus   : seven_seg_scan_driver_if.slave (value/load in, busy,
//           overflow, segments, digit enables out)
//   Optional feature: define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_scan_driver
   import seven_seg_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned DIGITS      = 3,
   parameter int unsigned REFRESH_DIV = 1000
) (
   input logic                    clk_i,
   input logic                    rst_i,
   seven_seg_scan_driver_if.slave bus
);

   localparam int unsigned BCDW = 4 * DIGITS;
   localparam int unsigned CNTW = $clog2(WIDTH + 1);
   localparam int unsigned PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CW   = (WIDTH > 64) ? WIDTH : 64;
   localparam logic [CW-1:0] LIMIT = CW'(pow10(DIGITS));

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic [BCDW-1:0]   bcd_q, bcd_d, adj;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [BCDW-1:0]   disp_q, disp_d;
   logic              ovf_q, ovf_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [7:0]        seg_q, seg_d;
   logic [DIGITS-1:0] en_q, en_d;
   logic [3:0]        nib_sel;
   logic              blank_sel;
   logic              busy;

   // FSM state register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.load_i) state_d = SHIFT;
         SHIFT:   if (cnt_q == CNTW'(1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = (state_q != IDLE);
   end

   // Converter datapath
   always_comb begin
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_pend_d = ovf_pend_q;
      disp_d     = disp_q;
      ovf_d      = ovf_q;
      adj        = bcd_q;
      case (state_q)
         IDLE: if (bus.load_i) begin
            bin_d      = bus.value_i;
            bcd_d      = '0;
            cnt_d      = CNTW'(WIDTH);
            // The value is shifted away during conversion, so the overflow
            // decision is taken at capture and held until DONE.
            ovf_pend_d = (CW'(bus.value_i) >= LIMIT);
         end
         SHIFT: begin
            for (int unsigned i = 0; i < DIGITS; i++)
               if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            bcd_d = {adj[BCDW-2:0], bin_q[WIDTH-1]};
            bin_d = {bin_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - CNTW'(1);
         end
         DONE: begin
            disp_d = bcd_q;
            ovf_d  = ovf_pend_q;
         end
         default: ;
      endcase
   end

   // Scan counter
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
      for (int unsigned i = 0; i < DIGITS; i++) en_d[i] = (idx_d == IW'(i));
   end

   // Segment source is taken from next-state display and index so that a
   // display update and a digit change both land on the same edge as the
   // registered segment byte: no stale digit is ever shown.
`ifdef SEVEN_SEG_LZB_EN
   logic [DIGITS-1:0] lz;
   logic              lead;
`endif

   always_comb begin
      nib_sel   = ovf_d ? 4'hF : disp_d[{idx_d, 2'b00} +: 4];
      blank_sel = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
      lz   = '0;
      lead = 1'b1;
      for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
         lead  = lead & (disp_d[4*i +: 4] == 4'd0);
         lz[i] = lead;
      end
      blank_sel = lz[idx_d] & ~ovf_d;
`endif
   end

   seven_seg_encoder u_enc (
      .nibble_i (nib_sel),
      .blank_i  (blank_sel),
      .seg_o    (seg_d)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_pend_q <= 1'b0;
         disp_q     <= '0;
         ovf_q      <= 1'b0;
         presc_q    <= '0;
         idx_q      <= '0;
         seg_q      <= SEG_0;
         en_q       <= DIGITS'(1);
      end else begin
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_pend_q <= ovf_pend_d;
         disp_q     <= disp_d;
         ovf_q      <= ovf_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         seg_q      <= seg_d;
         en_q       <= en_d;
      end
   end

   assign bus.busy_o     = busy;
   assign bus.overflow_o = ovf_q;
   assign bus.segments_o = seg_q;
   assign bus.digit_en_o = en_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver
//   Directed bench for seven_seg_scan_driver (WIDTH=8, REFRESH_DIV=4) with
//   a 3-digit instance and a 2-digit instance. Expected displays are queued
//   when a load is issued and compared once the conversion completes.
//   Honours SEVEN_SEG_LZB_EN for the leading-zero expectations.
module tb_seven_seg_scan_driver;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seven_seg_scan_driver_if #(.WIDTH(8), .DIGITS(3)) bus3 ();
   seven_seg_scan_driver_if #(.WIDTH(8), .DIGITS(2)) bus2 ();

   seven_seg_scan_driver #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u_dut3 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus3)
   );

   seven_seg_scan_driver #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(4)) u_dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2)
   );

   typedef struct packed {
      logic            ovf;
      logic [2:0][7:0] seg;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [7:0] enc(input int unsigned d);
      case (d)
         0: return 8'h3F;
         1: return 8'h06;
         2: return 8'h5B;
         3: return 8'h4F;
         4: return 8'h66;
         5: return 8'h6D;
         6: return 8'h7D;
         7: return 8'h07;
         8: return 8'h7F;
         default: return 8'h6F;
      endcase
   endfunction

   function automatic exp_t model(input int unsigned v, input int nd);
      exp_t        e;
      int unsigned lim;
      int unsigned p;
      int unsigned dig;
`ifdef SEVEN_SEG_LZB_EN
      logic        lead;
      lead = 1'b1;
`endif
      e   = '0;
      lim = 1;
      for (int k = 0; k < nd; k++) lim = lim * 10;
      e.ovf = (v >= lim);
      for (int i = nd - 1; i >= 0; i--) begin
         p = 1;
         for (int k = 0; k < i; k++) p = p * 10;
         dig = (v / p) % 10;
         if (e.ovf) begin
            e.seg[i] = 8'h40;
         end else begin
`ifdef SEVEN_SEG_LZB_EN
            lead     = lead && (dig == 0) && (i != 0);
            e.seg[i] = lead ? 8'h00 : enc(dig);
`else
            e.seg[i] = enc(dig);
`endif
         end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts busy-high samples on the 3-digit unit until it goes idle.
   task automatic wait_idle3(output int hi);
      int n;
      hi = 0;
      n  = 0;
      while (bus3.busy_o === 1'b1 && n < 40) begin
         hi++;
         n++;
         tick();
      end
      if (n >= 40) chk("busy3_timeout", 32'(bus3.busy_o), 0);
   endtask

   task automatic wait_idle2();
      int n;
      n = 0;
      while (bus2.busy_o === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      if (n >= 40) chk("busy2_timeout", 32'(bus2.busy_o), 0);
   endtask

   task automatic check_display3(input string tag);
      exp_t       e;
      logic [2:0] want;
      int         n;
      e = sb.pop_front();
      chk({tag, "_ovf"}, 32'(bus3.overflow_o), 32'(e.ovf));
      for (int d = 0; d < 3; d++) begin
         want = 3'(1 << d);
         n = 0;
         while (bus3.digit_en_o !== want && n < 20) begin
            tick();
            n++;
         end
         chk($sformatf("%s_en%0d", tag, d), 32'(bus3.digit_en_o), 32'(want));
         chk($sformatf("%s_seg%0d", tag, d), 32'(bus3.segments_o), 32'(e.seg[d]));
      end
   endtask

   task automatic check_display2(input string tag);
      exp_t       e;
      logic [1:0] want;
      int         n;
      e = sb.pop_front();
      chk({tag, "_ovf"}, 32'(bus2.overflow_o), 32'(e.ovf));
      for (int d = 0; d < 2; d++) begin
         want = 2'(1 << d);
         n = 0;
         while (bus2.digit_en_o !== want && n < 20) begin
            tick();
            n++;
         end
         chk($sformatf("%s_en%0d", tag, d), 32'(bus2.digit_en_o), 32'(want));
         chk($sformatf("%s_seg%0d", tag, d), 32'(bus2.segments_o), 32'(e.seg[d]));
      end
   endtask

   task automatic load3(input int unsigned v);
      bus3.value_i = 8'(v);
      bus3.load_i  = 1'b1;
      sb.push_back(model(v, 3));
      tick();
      bus3.load_i  = 1'b0;
   endtask

   task automatic load2(input int unsigned v);
      bus2.value_i = 8'(v);
      bus2.load_i  = 1'b1;
      sb.push_back(model(v, 2));
      tick();
      bus2.load_i  = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  hi;
      logic seen_busy;

      rst          = 1'b1;
      bus3.value_i = '0;
      bus3.load_i  = 1'b0;
      bus2.value_i = '0;
      bus2.load_i  = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_seg", 32'(bus3.segments_o), 32'h3F);
      chk("rst_en", 32'(bus3.digit_en_o), 32'b001);
      chk("rst_busy", 32'(bus3.busy_o), 0);
      chk("rst_ovf", 32'(bus3.overflow_o), 0);
      rst = 1'b0;

      // Scan cadence: 4 cycles per digit, wrap after 3 digits
      tick(); tick(); tick();
      chk("scan_3clk", 32'(bus3.digit_en_o), 32'b001);
      tick();
      chk("scan_4clk", 32'(bus3.digit_en_o), 32'b010);
      tick(); tick(); tick(); tick();
      chk("scan_8clk", 32'(bus3.digit_en_o), 32'b100);
      tick(); tick(); tick(); tick();
      chk("scan_12clk", 32'(bus3.digit_en_o), 32'b001);

      // 255: busy for cycles 1..9, shows 2/5/5
      load3(255);
      wait_idle3(hi);
      chk("busy_len_255", 32'(hi), 9);
      check_display3("v255");

      load3(7);
      wait_idle3(hi);
      check_display3("v7");

      load3(0);
      wait_idle3(hi);
      check_display3("v0");

      // Load during busy is dropped
      load3(100);
      tick();
      tick();
      bus3.value_i = 8'd42;
      bus3.load_i  = 1'b1;
      tick();
      bus3.load_i  = 1'b0;
      wait_idle3(hi);
      chk("busy_len_drop", 32'(hi), 6);
      check_display3("v100");

      // Held load restarts on the first idle cycle
      bus3.value_i = 8'd5;
      bus3.load_i  = 1'b1;
      sb.push_back(model(5, 3));
      tick();
      wait_idle3(hi);
      chk("busy_len_hold", 32'(hi), 9);
      chk("hold_idle", 32'(bus3.busy_o), 0);
      tick();
      chk("hold_restart", 32'(bus3.busy_o), 1);
      bus3.load_i = 1'b0;
      wait_idle3(hi);
      check_display3("v5");

      // Reset in the middle of converting 99
      sb.push_back(model(0, 3));
      bus3.value_i = 8'd99;
      bus3.load_i  = 1'b1;
      tick();
      bus3.load_i  = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus3.busy_o), 0);
      chk("abort_seg", 32'(bus3.segments_o), 32'h3F);
      chk("abort_en", 32'(bus3.digit_en_o), 32'b001);
      tick();
      rst = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus3.busy_o !== 1'b0) seen_busy = 1'b1;
         tick();
      end
      chk("abort_no_busy", 32'(seen_busy), 0);
      check_display3("abort");

      // Two-digit unit: overflow boundary at 100
      load2(200);
      wait_idle2();
      check_display2("d2_v200");

      load2(99);
      wait_idle2();
      check_display2("d2_v99");

      load2(100);
      wait_idle2();
      check_display2("d2_v100");

      chk("sb_empty", 32'(sb.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
